// File: rtl/llr_interleaver.sv
// Single-buffer block interleaver between the turbo-loop SISO decoders.
// It fills one block of signed LLRs and then plays it back in permuted or inverse-permuted order.
module llr_interleaver #(
  parameter int DATA_W    = 10,
  parameter int BLOCK_LEN = 7,
  parameter int STEP      = 3,
  parameter int OFFSET    = 0,
  parameter int CNT_W     = 3
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] OFFSET_IDX = CNT_W'(OFFSET);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [BLOCK_LEN];
  logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q, perm_q;
  logic              mode_q;
  logic [CNT_W-1:0]  wr_addr, rd_addr;
  logic              in_fire, out_fire;

  // Modular add by STEP without a divider; both operands are below BLOCK_LEN, so one subtraction suffices.
  function automatic logic [CNT_W-1:0] perm_step(input logic [CNT_W-1:0] p);
    logic [CNT_W:0] sum;
    sum = {1'b0, p} + (CNT_W+1)'(STEP);
    if (sum >= (CNT_W+1)'(BLOCK_LEN)) begin
      sum = sum - (CNT_W+1)'(BLOCK_LEN);
    end
    return sum[CNT_W-1:0];
  endfunction

  assign in_ready_o  = (state_q != DRAIN);
  assign out_valid_o = (state_q == DRAIN);
  assign busy_o      = (state_q != IDLE);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    wr_addr = '0;
    if (state_q == IDLE) begin
      wr_addr = mode_i ? OFFSET_IDX : '0;
    end else begin
      wr_addr = mode_q ? perm_q : wr_cnt_q;
    end
  end

  assign rd_addr    = mode_q ? rd_cnt_q : perm_q;
  assign out_data_o = out_valid_o ? mem[rd_addr] : '0;
  assign out_last_o = out_valid_o && (rd_cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = FILL;
      FILL:    if (in_fire && wr_cnt_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   if (out_fire && rd_cnt_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters return to 0 at the end of each phase so they never pass BLOCK_LEN-1.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      perm_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            mode_q   <= mode_i;
            wr_cnt_q <= CNT_W'(1);
            perm_q   <= perm_step(OFFSET_IDX);
          end
        end
        FILL: begin
          if (in_fire) begin
            if (wr_cnt_q == LAST_IDX) begin
              wr_cnt_q <= '0;
              rd_cnt_q <= '0;
              perm_q   <= OFFSET_IDX;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
              perm_q   <= perm_step(perm_q);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_cnt_q <= (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + CNT_W'(1);
            perm_q   <= perm_step(perm_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      mem[wr_addr] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_llr_interleaver.sv
// Bench for llr_interleaver: table of block vectors fed through a scoreboard queue,
// plus reset-mid-drain and a non-default STEP/OFFSET instance.
module tb_llr_interleaver;

  localparam int DATA_W = 10;
  localparam int N      = 7;

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic [N-1:0][DATA_W-1:0] blk_t;
  typedef struct {
    logic mode;
    bit   rand_ready;
    bit   gap;
    bit   toggle_mode;
    bit   junk_in;
    blk_t ins;
    blk_t exp;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              mode_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [DATA_W-1:0] in_data_i, out_data_o;

  logic              b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [DATA_W-1:0] b_in_data, b_out_data;

  int    tests = 0;
  int    fails = 0;
  word_t exp_q[$];
  vec_t  tbl[6];

  always #5 clk_i = ~clk_i;

  llr_interleaver #(.DATA_W(DATA_W), .BLOCK_LEN(N), .STEP(3), .OFFSET(0), .CNT_W(3)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .mode_i(mode_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o));

  llr_interleaver #(.DATA_W(DATA_W), .BLOCK_LEN(N), .STEP(2), .OFFSET(1), .CNT_W(3)) dut2 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .mode_i(b_mode), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .in_data_i(b_in_data), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .out_data_o(b_out_data), .out_last_o(b_out_last), .busy_o(b_busy));

  function automatic int pi_f(int step, int off, int j);
    return (step * j + off) % N;
  endfunction

  function automatic blk_t build_exp(logic mode, blk_t ins);
    blk_t e;
    for (int i = 0; i < N; i++) begin
      if (!mode) e[i] = ins[pi_f(3, 0, i)];
      else       e[pi_f(3, 0, i)] = ins[i];
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one block from a negedge; leaves the bench at the negedge after the last input transfer.
  task automatic applyStimulus(input vec_t v);
    for (int j = 0; j < N; j++) exp_q.push_back($signed(v.exp[j]));
    for (int i = 0; i < N; i++) begin
      if (v.gap && i == 3) begin
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("fill_gap_busy", int'(busy_o), 1);
      end
      checkOutput("fill_in_ready", int'(in_ready_o), 1);
      in_valid_i = 1'b1;
      in_data_i  = v.ins[i];
      mode_i     = (v.toggle_mode && i > 0) ? ~v.mode : v.mode;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    checkOutput("first_out_latency", int'(out_valid_o), 1);
  endtask

  task automatic drainBlock(input bit rand_ready, input bit junk);
    int    guard = 0;
    bit    held  = 0;
    bit    r;
    word_t hd;
    logic  hl = 1'b0;
    word_t e;
    hd = '0;
    while (exp_q.size() > 0 && guard < 200) begin
      guard++;
      if (held) begin
        checkOutput("stall_hold_data", $signed(out_data_o), hd);
        checkOutput("stall_hold_last", int'(out_last_o), int'(hl));
      end
      checkOutput("drain_in_ready", int'(in_ready_o), 0);
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_i = r;
      if (junk) begin
        in_valid_i = 1'b1;
        in_data_i  = DATA_W'($urandom);
      end
      if (!out_valid_o) begin
        checkOutput("drain_out_valid", int'(out_valid_o), 1);
      end else if (r) begin
        e = exp_q.pop_front();
        checkOutput("out_data", $signed(out_data_o), e);
        checkOutput("out_last", int'(out_last_o), (exp_q.size() == 0) ? 1 : 0);
        held = 0;
      end else begin
        held = 1;
        hd   = $signed(out_data_o);
        hl   = out_last_o;
      end
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    checkOutput("drain_words_left", exp_q.size(), 0);
    exp_q.delete();
    checkOutput("idle_out_valid", int'(out_valid_o), 0);
    checkOutput("idle_busy", int'(busy_o), 0);
    checkOutput("idle_in_ready", int'(in_ready_o), 1);
  endtask

  initial begin
    blk_t rnd, seq;
    int   j, guard;
    int   b_exp[N] = '{1, 3, 5, 0, 2, 4, 6};

    reset_n_i = 1'b0; mode_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #12;
    checkOutput("reset_in_ready", int'(in_ready_o), 1);
    checkOutput("reset_out_valid", int'(out_valid_o), 0);
    checkOutput("reset_out_last", int'(out_last_o), 0);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_out_data", int'(out_data_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    seq = {10'sd50, 10'sd20, 10'sd60, 10'sd30, 10'sd70, 10'sd40, 10'sd10};
    tbl[0] = '{mode: 1'b0, rand_ready: 0, gap: 0, toggle_mode: 0, junk_in: 0,
               ins: {10'sd70, 10'sd60, 10'sd50, 10'sd40, 10'sd30, 10'sd20, 10'sd10}, exp: seq};
    tbl[1] = '{mode: 1'b1, rand_ready: 0, gap: 0, toggle_mode: 0, junk_in: 0,
               ins: seq, exp: {10'sd70, 10'sd60, 10'sd50, 10'sd40, 10'sd30, 10'sd20, 10'sd10}};
    for (int i = 0; i < N; i++) rnd[i] = DATA_W'($urandom);
    rnd[0] = -10'sd512;
    rnd[1] = 10'sd511;
    tbl[2] = '{mode: 1'b0, rand_ready: 0, gap: 0, toggle_mode: 0, junk_in: 0,
               ins: rnd, exp: build_exp(1'b0, rnd)};
    tbl[3] = '{mode: 1'b1, rand_ready: 0, gap: 0, toggle_mode: 0, junk_in: 0,
               ins: build_exp(1'b0, rnd), exp: rnd};
    for (int i = 0; i < N; i++) rnd[i] = DATA_W'($urandom);
    tbl[4] = '{mode: 1'b1, rand_ready: 1, gap: 0, toggle_mode: 0, junk_in: 1,
               ins: rnd, exp: build_exp(1'b1, rnd)};
    tbl[5] = '{mode: 1'b0, rand_ready: 1, gap: 1, toggle_mode: 1, junk_in: 0,
               ins: seq, exp: build_exp(1'b0, seq)};

    for (int k = 0; k < 6; k++) begin
      applyStimulus(tbl[k]);
      drainBlock(tbl[k].rand_ready, tbl[k].junk_in);
    end

    // Reset in the middle of DRAIN after three words have left.
    applyStimulus(tbl[0]);
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("pre_reset_data", $signed(out_data_o), 30);
    #2 reset_n_i = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", int'(out_valid_o), 0);
    checkOutput("async_reset_in_ready", int'(in_ready_o), 1);
    checkOutput("async_reset_busy", int'(busy_o), 0);
    @(negedge clk_i);
    reset_n_i   = 1'b1;
    out_ready_i = 1'b0;
    exp_q.delete();
    applyStimulus(tbl[0]);
    drainBlock(1'b0, 1'b0);

    // STEP=2, OFFSET=1 instance: interleave 0..6.
    b_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = DATA_W'(i);
      @(negedge clk_i);
    end
    b_in_valid = 1'b0;
    j = 0;
    guard = 0;
    while (j < N && guard < 50) begin
      if (b_out_valid) begin
        checkOutput("alt_perm_data", $signed(b_out_data), b_exp[j]);
        checkOutput("alt_perm_last", int'(b_out_last), (j == N - 1) ? 1 : 0);
        j++;
      end
      guard++;
      @(negedge clk_i);
    end
    checkOutput("alt_perm_count", j, N);
    checkOutput("alt_idle_busy", int'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
